pipe_tracker: RTL and testbench



---
 rtl/pipe_tracker_if.sv | 49 ++++
 rtl/pipe_tracker.sv | 78 +++++++
 tb/tb_pipe_tracker.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_tracker_if.sv
// pipe_tracker_if: decode/hazard-side signals consumed by pipe_tracker and
// the per-stage metadata it drives back. Counter signals exist only when
// PIPE_PERF_EN is defined.
interface pipe_tracker_if #(
   parameter int REG_SIZE = 5,
   parameter int CNT_W    = 32
);
   // decode / hazard inputs
   logic                fetchValidF;
   logic                regWriteD;
   logic                mem2regD;
   logic [REG_SIZE-1:0] writeRegD;
   logic                stallF;
   logic                stallD;
   logic                flushD;
   logic                flushE;
   // per-stage metadata
   logic                validD, validE, validM, validW;
   logic                regWriteE, regWriteM, regWriteW;
   logic                mem2regE, mem2regM;
   logic [REG_SIZE-1:0] writeRegE, writeRegM, writeRegW;
`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0]    stallCycles, flushCycles, retired;
`endif

   modport master (
      output fetchValidF, regWriteD, mem2regD, writeRegD,
      output stallF, stallD, flushD, flushE,
      input  validD, validE, validM, validW,
      input  regWriteE, regWriteM, regWriteW,
      input  mem2regE, mem2regM,
`ifdef PIPE_PERF_EN
      input  stallCycles, flushCycles, retired,
`endif
      input  writeRegE, writeRegM, writeRegW
   );

   modport slave (
      input  fetchValidF, regWriteD, mem2regD, writeRegD,
      input  stallF, stallD, flushD, flushE,
      output validD, validE, validM, validW,
      output regWriteE, regWriteM, regWriteW,
      output mem2regE, mem2regM,
`ifdef PIPE_PERF_EN
      output stallCycles, flushCycles, retired,
`endif
      output writeRegE, writeRegM, writeRegW
   );
endinterface

// File: rtl/pipe_tracker.sv
// pipe_tracker: per-stage valid bits and destination metadata for D/E/M/W.
// Applies hazard stall/flush commands; all outputs registered.
// Optional macro PIPE_PERF_EN adds stall/flush/retire counters.
module pipe_tracker #(
   parameter int REG_SIZE = 5,
   parameter int CNT_W    = 32
) (
   input  logic          clk,
   input  logic          reset,
   pipe_tracker_if.slave bif
);
   localparam logic [REG_SIZE-1:0] NOREG = '0;

   // stallF only mirrors stallD for external invariant checking
   logic unused_stallF;
   assign unused_stallF = bif.stallF;

   // D valid: stall holds (beats flush), flush squashes, else capture fetch
   always_ff @(posedge clk) begin
      if (reset)            bif.validD <= 1'b0;
      else if (bif.stallD)  bif.validD <= bif.validD;
      else if (bif.flushD)  bif.validD <= 1'b0;
      else                  bif.validD <= bif.fetchValidF;
   end

   // E: bubble on flush, else take D metadata gated by validD
   always_ff @(posedge clk) begin
      if (reset || bif.flushE) begin
         bif.validE    <= 1'b0;
         bif.regWriteE <= 1'b0;
         bif.mem2regE  <= 1'b0;
         bif.writeRegE <= NOREG;
      end else begin
         bif.validE    <= bif.validD;
         bif.regWriteE <= bif.regWriteD & bif.validD;
         bif.mem2regE  <= bif.mem2regD & bif.validD;
         bif.writeRegE <= bif.validD ? bif.writeRegD : NOREG;
      end
   end

   // M and W: unconditional copies of the previous stage
   always_ff @(posedge clk) begin
      if (reset) begin
         bif.validM    <= 1'b0;
         bif.regWriteM <= 1'b0;
         bif.mem2regM  <= 1'b0;
         bif.writeRegM <= NOREG;
         bif.validW    <= 1'b0;
         bif.regWriteW <= 1'b0;
         bif.writeRegW <= NOREG;
      end else begin
         bif.validM    <= bif.validE;
         bif.regWriteM <= bif.regWriteE;
         bif.mem2regM  <= bif.mem2regE;
         bif.writeRegM <= bif.writeRegE;
         bif.validW    <= bif.validM;
         bif.regWriteW <= bif.regWriteM;
         bif.writeRegW <= bif.writeRegM;
      end
   end

`ifdef PIPE_PERF_EN
   // counters wrap naturally; a cycle with both flushes counts once
   always_ff @(posedge clk) begin
      if (reset) begin
         bif.stallCycles <= '0;
         bif.flushCycles <= '0;
         bif.retired     <= '0;
      end else begin
         bif.stallCycles <= bif.stallCycles + {{(CNT_W-1){1'b0}}, bif.stallD};
         bif.flushCycles <= bif.flushCycles + {{(CNT_W-1){1'b0}}, bif.flushD | bif.flushE};
         bif.retired     <= bif.retired + {{(CNT_W-1){1'b0}}, bif.validW};
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_pipe_tracker.sv
// Directed bench for pipe_tracker; perf checks active with PIPE_PERF_EN.
module tb_pipe_tracker;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   nt = 0;
   int   nf = 0;

   always #5 clk = ~clk;

   pipe_tracker_if #(.REG_SIZE(5), .CNT_W(32)) pif ();
   pipe_tracker #(.REG_SIZE(5), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bif(pif));

   // drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic drive(input logic fv, input logic rw, input logic m2r,
                        input logic [4:0] wr, input logic sd, input logic fd,
                        input logic fe);
      pif.fetchValidF = fv;
      pif.regWriteD   = rw;
      pif.mem2regD    = m2r;
      pif.writeRegD   = wr;
      pif.stallF      = sd;
      pif.stallD      = sd;
      pif.flushD      = fd;
      pif.flushE      = fe;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      nt++; if ({pif.validD, pif.validE, pif.validM, pif.validW} !== 4'b0) begin nf++; $display("FAIL reset_valid: got %b exp 0000", {pif.validD, pif.validE, pif.validM, pif.validW}); end
      nt++; if ({pif.regWriteE, pif.regWriteM, pif.regWriteW, pif.mem2regE, pif.mem2regM} !== 5'b0) begin nf++; $display("FAIL reset_ctrl: got %b exp 00000", {pif.regWriteE, pif.regWriteM, pif.regWriteW, pif.mem2regE, pif.mem2regM}); end
      nt++; if ({pif.writeRegE, pif.writeRegM, pif.writeRegW} !== 15'b0) begin nf++; $display("FAIL reset_wreg: got %h exp 0", {pif.writeRegE, pif.writeRegM, pif.writeRegW}); end
`ifdef PIPE_PERF_EN
      nt++; if ({pif.stallCycles, pif.flushCycles, pif.retired} !== 96'b0) begin nf++; $display("FAIL reset_cnt: got %h exp 0", {pif.stallCycles, pif.flushCycles, pif.retired}); end
`endif
   endtask

   task automatic test_stream();
      do_reset();
      drive(1, 0, 0, 5'd0, 0, 0, 0);                 // first fetch
      nt++; if (pif.validD !== 1'b1) begin nf++; $display("FAIL stream_vD: got %b exp 1", pif.validD); end
      drive(1, 1, 0, 5'd1, 0, 0, 0);
      nt++; if (pif.writeRegE !== 5'd1 || pif.regWriteE !== 1'b1) begin nf++; $display("FAIL stream_E1: got wr=%0d rw=%b exp wr=1 rw=1", pif.writeRegE, pif.regWriteE); end
      drive(1, 1, 0, 5'd2, 0, 0, 0);
      nt++; if (pif.writeRegM !== 5'd1 || pif.writeRegE !== 5'd2) begin nf++; $display("FAIL stream_M1: got M=%0d E=%0d exp M=1 E=2", pif.writeRegM, pif.writeRegE); end
      drive(1, 1, 0, 5'd3, 0, 0, 0);
      nt++; if (pif.writeRegW !== 5'd1 || pif.regWriteW !== 1'b1 || pif.validW !== 1'b1) begin nf++; $display("FAIL stream_W1: got wr=%0d rw=%b v=%b exp 1 1 1", pif.writeRegW, pif.regWriteW, pif.validW); end
      // r0 destination with regWrite is carried unchanged
      drive(0, 1, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.regWriteE !== 1'b1 || pif.writeRegE !== 5'd0 || pif.validE !== 1'b1) begin nf++; $display("FAIL stream_r0: got rw=%b wr=%0d v=%b exp 1 0 1", pif.regWriteE, pif.writeRegE, pif.validE); end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1, 0, 0, 5'd0, 0, 0, 0);                 // fetch load
      drive(1, 1, 1, 5'd5, 0, 0, 0);                 // load r5 in D, dependent fetched
      nt++; if (pif.mem2regE !== 1'b1 || pif.writeRegE !== 5'd5) begin nf++; $display("FAIL lu_loadE: got m2r=%b wr=%0d exp 1 5", pif.mem2regE, pif.writeRegE); end
      drive(1, 1, 0, 5'd6, 1, 0, 1);                 // load-use stall
      nt++; if (pif.validE !== 1'b0 || pif.writeRegE !== 5'd0 || pif.validD !== 1'b1) begin nf++; $display("FAIL lu_bubble: got vE=%b wrE=%0d vD=%b exp 0 0 1", pif.validE, pif.writeRegE, pif.validD); end
      nt++; if (pif.mem2regM !== 1'b1 || pif.writeRegM !== 5'd5) begin nf++; $display("FAIL lu_loadM: got m2r=%b wr=%0d exp 1 5", pif.mem2regM, pif.writeRegM); end
      drive(0, 1, 0, 5'd6, 0, 0, 0);
      nt++; if (pif.writeRegE !== 5'd6 || pif.writeRegW !== 5'd5) begin nf++; $display("FAIL lu_dep: got E=%0d W=%0d exp 6 5", pif.writeRegE, pif.writeRegW); end
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.writeRegW !== 5'd0 || pif.validW !== 1'b0 || pif.validE !== 1'b0) begin nf++; $display("FAIL lu_W0: got W=%0d vW=%b vE=%b exp 0 0 0", pif.writeRegW, pif.validW, pif.validE); end
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.writeRegW !== 5'd6 || pif.validW !== 1'b1) begin nf++; $display("FAIL lu_W6: got W=%0d vW=%b exp 6 1", pif.writeRegW, pif.validW); end
   endtask

   task automatic test_flush();
      do_reset();
      drive(1, 0, 0, 5'd0, 0, 0, 0);
      drive(1, 1, 0, 5'd7, 0, 1, 0);                 // branch flushD
      nt++; if (pif.validD !== 1'b0 || pif.writeRegE !== 5'd7) begin nf++; $display("FAIL fl_D: got vD=%b wrE=%0d exp 0 7", pif.validD, pif.writeRegE); end
      drive(1, 1, 0, 5'd9, 0, 0, 0);                 // D metadata must be gated
      nt++; if (pif.validE !== 1'b0 || pif.regWriteE !== 1'b0 || pif.writeRegE !== 5'd0) begin nf++; $display("FAIL fl_gate: got v=%b rw=%b wr=%0d exp 0 0 0", pif.validE, pif.regWriteE, pif.writeRegE); end
      drive(0, 1, 0, 5'd10, 0, 0, 0);
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.validW !== 1'b0 || pif.regWriteW !== 1'b0 || pif.writeRegW !== 5'd0) begin nf++; $display("FAIL fl_W: got v=%b rw=%b wr=%0d exp 0 0 0", pif.validW, pif.regWriteW, pif.writeRegW); end
   endtask

   task automatic test_priority();
      do_reset();
      drive(1, 0, 0, 5'd0, 0, 0, 0);
      drive(0, 1, 0, 5'd4, 1, 1, 1);                 // stall beats flushD
      nt++; if (pif.validD !== 1'b1 || pif.validE !== 1'b0) begin nf++; $display("FAIL prio: got vD=%b vE=%b exp 1 0", pif.validD, pif.validE); end
      drive(1, 1, 0, 5'd3, 0, 1, 1);                 // both flushes, no stall
      nt++; if (pif.validD !== 1'b0 || pif.validE !== 1'b0 || pif.writeRegE !== 5'd0) begin nf++; $display("FAIL dflush: got vD=%b vE=%b wrE=%0d exp 0 0 0", pif.validD, pif.validE, pif.writeRegE); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 0, 0, 5'd0, 0, 0, 0);
      drive(1, 1, 0, 5'd1, 0, 0, 0);
      drive(1, 1, 1, 5'd2, 0, 0, 0);
      drive(1, 1, 0, 5'd3, 0, 0, 0);
      nt++; if ({pif.validD, pif.validE, pif.validM, pif.validW} !== 4'b1111) begin nf++; $display("FAIL rm_full: got %b exp 1111", {pif.validD, pif.validE, pif.validM, pif.validW}); end
      reset = 1'b1;
      drive(1, 1, 0, 5'd4, 0, 0, 0);
      reset = 1'b0;
      nt++; if ({pif.validD, pif.validE, pif.validM, pif.validW, pif.regWriteE, pif.regWriteM, pif.regWriteW, pif.mem2regE, pif.mem2regM} !== 9'b0) begin nf++; $display("FAIL rm_ctrl: got %b exp 0", {pif.validD, pif.validE, pif.validM, pif.validW, pif.regWriteE, pif.regWriteM, pif.regWriteW, pif.mem2regE, pif.mem2regM}); end
      nt++; if ({pif.writeRegE, pif.writeRegM, pif.writeRegW} !== 15'b0) begin nf++; $display("FAIL rm_wreg: got %h exp 0", {pif.writeRegE, pif.writeRegM, pif.writeRegW}); end
      drive(1, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.validD !== 1'b1 || pif.validE !== 1'b0) begin nf++; $display("FAIL rm_refD: got vD=%b vE=%b exp 1 0", pif.validD, pif.validE); end
      drive(0, 1, 0, 5'd11, 0, 0, 0);
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      drive(0, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.writeRegW !== 5'd11 || pif.regWriteW !== 1'b1) begin nf++; $display("FAIL rm_refW: got wr=%0d rw=%b exp 11 1", pif.writeRegW, pif.regWriteW); end
   endtask

`ifdef PIPE_PERF_EN
   task automatic test_perf();
      logic sd, fd;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         sd = (c == 3);
         fd = (c == 6);
         drive(1, 1, 0, 5'(c + 1), sd, fd, sd);
      end
      for (int c = 0; c < 6; c++) drive(0, 0, 0, 5'd0, 0, 0, 0);
      nt++; if (pif.stallCycles !== 32'd1) begin nf++; $display("FAIL perf_stall: got %0d exp 1", pif.stallCycles); end
      nt++; if (pif.flushCycles !== 32'd2) begin nf++; $display("FAIL perf_flush: got %0d exp 2", pif.flushCycles); end
      nt++; if (pif.retired !== 32'd9) begin nf++; $display("FAIL perf_retired: got %0d exp 9", pif.retired); end
   endtask
`endif

   initial begin
      pif.fetchValidF = 1'b0; pif.regWriteD = 1'b0; pif.mem2regD = 1'b0;
      pif.writeRegD = 5'd0; pif.stallF = 1'b0; pif.stallD = 1'b0;
      pif.flushD = 1'b0; pif.flushE = 1'b0;
      test_reset();
      test_stream();
      test_load_use();
      test_flush();
      test_priority();
      test_reset_mid();
`ifdef PIPE_PERF_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", nt, nf);
      $finish;
   end
endmodule
